// File: rtl/body_pixel_renderer.sv
// Pixel-colour stage in front of the VGA pins. Draws up to NUM_BODIES squares
// over a background colour, with a double-buffered body table swapped only at
// frame boundaries. All outputs share a fixed two-cycle latency.
module body_pixel_renderer #(
    parameter int unsigned NUM_BODIES = 4,
    parameter int unsigned BODY_SIZE  = 4,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter int unsigned IDX_W      = (NUM_BODIES > 1) ? $clog2(NUM_BODIES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [9:0]       pix_x,
    input  logic [8:0]       pix_y,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             frame_start,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [9:0]       wr_x,
    input  logic [8:0]       wr_y,
    input  logic [23:0]      wr_color,
    input  logic             wr_vis,
    input  logic             commit,
    output logic             commit_pending,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             blank_n_out
);

    // Shadow bank (written by the physics core)
    logic [9:0]            sh_x_q     [NUM_BODIES];
    logic [9:0]            sh_x_d     [NUM_BODIES];
    logic [8:0]            sh_y_q     [NUM_BODIES];
    logic [8:0]            sh_y_d     [NUM_BODIES];
    logic [23:0]           sh_color_q [NUM_BODIES];
    logic [23:0]           sh_color_d [NUM_BODIES];
    logic [NUM_BODIES-1:0] sh_vis_q;
    logic [NUM_BODIES-1:0] sh_vis_d;

    // Active bank (read by the pixel path)
    logic [9:0]            act_x_q     [NUM_BODIES];
    logic [9:0]            act_x_d     [NUM_BODIES];
    logic [8:0]            act_y_q     [NUM_BODIES];
    logic [8:0]            act_y_d     [NUM_BODIES];
    logic [23:0]           act_color_q [NUM_BODIES];
    logic [23:0]           act_color_d [NUM_BODIES];
    logic [NUM_BODIES-1:0] act_vis_q;
    logic [NUM_BODIES-1:0] act_vis_d;

    logic commit_pending_q;
    logic commit_pending_d;
    logic swap;

    // Stage 1
    logic                  valid_s1_q;
    logic                  hs_s1_q;
    logic                  vs_s1_q;
    logic [NUM_BODIES-1:0] hit_s1_q;
    logic [NUM_BODIES-1:0] hit_s1_d;

    // Stage 2
    logic [23:0] rgb_q;
    logic [23:0] rgb_d;
    logic        hs_q;
    logic        vs_q;
    logic        blank_n_q;

    // A commit arriving together with frame_start is applied immediately.
    assign swap = frame_start & (commit_pending_q | commit);

    // Shadow bank next state: single-slot write; out-of-range indices match no slot.
    always_comb begin
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_color_d = sh_color_q;
        sh_vis_d   = sh_vis_q;
        for (int i = 0; i < int'(NUM_BODIES); i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                sh_x_d[i]     = wr_x;
                sh_y_d[i]     = wr_y;
                sh_color_d[i] = wr_color;
                sh_vis_d[i]   = wr_vis;
            end
        end
    end

    // Active bank next state: copy the pre-write shadow contents on a swap.
    always_comb begin
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        act_color_d = act_color_q;
        act_vis_d   = act_vis_q;
        if (swap) begin
            act_x_d     = sh_x_q;
            act_y_d     = sh_y_q;
            act_color_d = sh_color_q;
            act_vis_d   = sh_vis_q;
        end
    end

    // Commit request tracking; repeated commits while pending are absorbed.
    always_comb begin
        commit_pending_d = commit_pending_q;
        if (swap) begin
            commit_pending_d = 1'b0;
        end else if (commit) begin
            commit_pending_d = 1'b1;
        end
    end

    // Body table and commit flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_BODIES); i++) begin
                sh_x_q[i]      <= '0;
                sh_y_q[i]      <= '0;
                sh_color_q[i]  <= '0;
                act_x_q[i]     <= '0;
                act_y_q[i]     <= '0;
                act_color_q[i] <= '0;
            end
            sh_vis_q         <= '0;
            act_vis_q        <= '0;
            commit_pending_q <= 1'b0;
        end else begin
            sh_x_q           <= sh_x_d;
            sh_y_q           <= sh_y_d;
            sh_color_q       <= sh_color_d;
            sh_vis_q         <= sh_vis_d;
            act_x_q          <= act_x_d;
            act_y_q          <= act_y_d;
            act_color_q      <= act_color_d;
            act_vis_q        <= act_vis_d;
            commit_pending_q <= commit_pending_d;
        end
    end

    // Per-slot hit test; widened sums so bodies near the edge clip instead of wrapping.
    always_comb begin
        hit_s1_d = '0;
        for (int i = 0; i < int'(NUM_BODIES); i++) begin
            hit_s1_d[i] = act_vis_q[i]
                && (pix_x >= act_x_q[i])
                && ({1'b0, pix_x} < ({1'b0, act_x_q[i]} + 11'(BODY_SIZE)))
                && (pix_y >= act_y_q[i])
                && ({1'b0, pix_y} < ({1'b0, act_y_q[i]} + 10'(BODY_SIZE)));
        end
    end

    // Stage 1 registers: timing signals and hit vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_q <= 1'b0;
            hs_s1_q    <= 1'b1;
            vs_s1_q    <= 1'b1;
            hit_s1_q   <= '0;
        end else begin
            valid_s1_q <= pix_valid;
            hs_s1_q    <= hsync_in;
            vs_s1_q    <= vsync_in;
            hit_s1_q   <= hit_s1_d;
        end
    end

    // Colour select: descending scan so the lowest-index hit wins.
    always_comb begin
        rgb_d = '0;
        if (valid_s1_q) begin
            rgb_d = BG_COLOR;
            for (int i = int'(NUM_BODIES) - 1; i >= 0; i--) begin
                if (hit_s1_q[i]) begin
                    rgb_d = act_color_q[i];
                end
            end
        end
    end

    // Stage 2 registers drive the pins directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hs_q      <= hs_s1_q;
            vs_q      <= vs_s1_q;
            blank_n_q <= valid_s1_q;
        end
    end

    assign r              = rgb_q[23:16];
    assign g              = rgb_q[15:8];
    assign b              = rgb_q[7:0];
    assign hsync_out      = hs_q;
    assign vsync_out      = vs_q;
    assign blank_n_out    = blank_n_q;
    assign commit_pending = commit_pending_q;

endmodule

// File: tb/tb_body_pixel_renderer.sv
// Self-checking bench for body_pixel_renderer: table vectors, directed
// sequences and randomized traffic against a behavioural frame model.
module tb_body_pixel_renderer;

    localparam int          NB = 4;
    localparam int          BS = 4;
    localparam logic [23:0] BG = 24'h123456;

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] MAG   = 24'hFF00FF;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] YEL   = 24'hFFFF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_start;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [23:0] wr_color;
    logic        wr_vis;
    logic        commit;
    logic        commit_pending;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_n_out;

    always #5 clk = ~clk;

    body_pixel_renderer #(
        .NUM_BODIES (NB),
        .BODY_SIZE  (BS),
        .BG_COLOR   (BG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .frame_start    (frame_start),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_x           (wr_x),
        .wr_y           (wr_y),
        .wr_color       (wr_color),
        .wr_vis         (wr_vis),
        .commit         (commit),
        .commit_pending (commit_pending),
        .r              (r),
        .g              (g),
        .b              (b),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .blank_n_out    (blank_n_out)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: two body tables, a pending flag and a two-deep output pipe.
    int          m_sh_x  [NB];
    int          m_sh_y  [NB];
    logic [23:0] m_sh_c  [NB];
    bit          m_sh_v  [NB];
    int          m_act_x [NB];
    int          m_act_y [NB];
    logic [23:0] m_act_c [NB];
    bit          m_act_v [NB];
    bit          m_pend;
    logic [23:0] s1_rgb, o_rgb;
    bit          s1_hs, s1_vs, s1_bl, o_hs, o_vs, o_bl;

    typedef struct {
        int          x;
        int          y;
        bit          v;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_color(input int px, input int py, input bit valid);
        if (!valid) return 24'h0;
        for (int i = 0; i < NB; i++) begin
            if (m_act_v[i] && px >= m_act_x[i] && px < m_act_x[i] + BS
                && py >= m_act_y[i] && py < m_act_y[i] + BS) return m_act_c[i];
        end
        return BG;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_c[i] = 0; m_sh_v[i] = 0;
            m_act_x[i] = 0; m_act_y[i] = 0; m_act_c[i] = 0; m_act_v[i] = 0;
        end
        m_pend = 0;
        s1_rgb = 0; s1_hs = 1; s1_vs = 1; s1_bl = 0;
        o_rgb = 0; o_hs = 1; o_vs = 1; o_bl = 0;
    endtask

    // One clock: advance the model with the inputs now driven, then compare everything.
    task automatic step();
        logic [23:0] n_rgb;
        bit          do_swap;
        n_rgb   = ref_color(int'(pix_x), int'(pix_y), pix_valid);
        do_swap = frame_start && (m_pend || commit);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            o_rgb = s1_rgb; o_hs = s1_hs; o_vs = s1_vs; o_bl = s1_bl;
            s1_rgb = n_rgb; s1_hs = hsync_in; s1_vs = vsync_in; s1_bl = pix_valid;
            if (do_swap) begin
                m_act_x = m_sh_x; m_act_y = m_sh_y; m_act_c = m_sh_c; m_act_v = m_sh_v;
            end
            if (wr_en && int'(wr_idx) < NB) begin
                m_sh_x[wr_idx] = int'(wr_x);
                m_sh_y[wr_idx] = int'(wr_y);
                m_sh_c[wr_idx] = wr_color;
                m_sh_v[wr_idx] = wr_vis;
            end
            if (do_swap) m_pend = 0;
            else if (commit) m_pend = 1;
        end
        #1;
        check("rgb", {8'h0, r, g, b}, {8'h0, o_rgb});
        check("hsync_out", 32'(hsync_out), 32'(o_hs));
        check("vsync_out", 32'(vsync_out), 32'(o_vs));
        check("blank_n_out", 32'(blank_n_out), 32'(o_bl));
        check("commit_pending", 32'(commit_pending), 32'(m_pend));
        wr_en = 0; commit = 0; frame_start = 0;
    endtask

    task automatic pix(input int x, input int y, input bit v);
        pix_x = 10'(x); pix_y = 9'(y); pix_valid = v;
        hsync_in = 1'($urandom); vsync_in = 1'($urandom);
        step();
    endtask

    task automatic idle();
        pix(0, 0, 0);
    endtask

    task automatic write_slot(input int idx, input int x, input int y, input logic [23:0] c,
                              input bit v);
        wr_en = 1; wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 9'(y); wr_color = c; wr_vis = v;
        idle();
    endtask

    task automatic commit_and_swap();
        commit = 1;
        idle();
        check("pending_after_commit", 32'(commit_pending), 32'd1);
        frame_start = 1;
        idle();
        check("pending_after_swap", 32'(commit_pending), 32'd0);
    endtask

    // Probe one pixel and compare the displayed colour with a hand-derived value.
    task automatic probe(input string name, input int x, input int y, input bit v,
                         input logic [23:0] exp);
        pix(x, y, v);
        idle();
        check(name, {8'h0, r, g, b}, {8'h0, exp});
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1,
                        input logic [23:0] c, output int cnt);
        cnt = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                pix(x, y, 1);
                if (blank_n_out && {r, g, b} == c) cnt++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            idle();
            if (blank_n_out && {r, g, b} == c) cnt++;
        end
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{100, 50, 1, RED};   tbl[1]  = '{103, 53, 1, RED};
        tbl[2]  = '{104, 50, 1, BG};    tbl[3]  = '{99, 50, 1, BG};
        tbl[4]  = '{100, 54, 1, BG};    tbl[5]  = '{638, 478, 1, MAG};
        tbl[6]  = '{639, 479, 1, MAG};  tbl[7]  = '{637, 478, 1, BG};
        tbl[8]  = '{0, 0, 1, BG};       tbl[9]  = '{0, 478, 1, BG};
        tbl[10] = '{638, 0, 1, BG};     tbl[11] = '{22, 22, 1, GREEN};
        tbl[12] = '{23, 23, 1, GREEN};  tbl[13] = '{24, 24, 1, BLUE};
        tbl[14] = '{25, 25, 1, BLUE};   tbl[15] = '{26, 26, 1, BG};
        tbl[16] = '{20, 20, 1, GREEN};  tbl[17] = '{100, 50, 0, 24'h0};
        tbl[18] = '{21, 24, 1, BG};     tbl[19] = '{24, 21, 1, BG};

        rst = 1; pix_valid = 0; pix_x = 0; pix_y = 0; hsync_in = 1; vsync_in = 1;
        frame_start = 0; wr_en = 0; wr_idx = 0; wr_x = 0; wr_y = 0; wr_color = 0;
        wr_vis = 0; commit = 0;
        model_clear();
        step(); step();
        check("reset_rgb", {8'h0, r, g, b}, 32'h0);
        check("reset_hsync", 32'(hsync_out), 32'd1);
        check("reset_vsync", 32'(vsync_out), 32'd1);
        check("reset_blank_n", 32'(blank_n_out), 32'd0);
        check("reset_pending", 32'(commit_pending), 32'd0);
        rst = 0;

        // One active line of background with random syncs.
        for (int x = 0; x < 640; x++) pix(x, 10, 1);
        idle(); idle();

        // Single body, exactly 16 red pixels.
        write_slot(0, 100, 50, RED, 1);
        commit_and_swap();
        scan(90, 115, 45, 60, RED, cnt);
        check("red_count_16", 32'(cnt), 32'd16);

        // Bottom-right body is clipped, never wrapped.
        write_slot(0, 638, 478, RED, 1);
        commit_and_swap();
        scan(630, 639, 472, 479, RED, cnt);
        check("corner_count_4", 32'(cnt), 32'd4);
        scan(0, 3, 476, 479, RED, cnt);
        check("no_wrap_left", 32'(cnt), 32'd0);
        scan(634, 639, 0, 2, RED, cnt);
        check("no_wrap_top", 32'(cnt), 32'd0);

        // Table scene: overlap plus edge and isolated bodies.
        write_slot(0, 20, 20, GREEN, 1);
        write_slot(1, 22, 22, BLUE, 1);
        write_slot(2, 100, 50, RED, 1);
        write_slot(3, 638, 478, MAG, 1);
        commit_and_swap();
        for (int i = 0; i < 20; i++) probe($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y,
                                           tbl[i].v, tbl[i].rgb);

        // Mid-frame write without commit leaves the frame untouched.
        write_slot(0, 300, 300, WHITE, 1);
        probe("midframe_old", 20, 20, 1, GREEN);
        probe("midframe_new", 300, 300, 1, BG);
        frame_start = 1;
        idle();
        probe("fs_nocommit_old", 20, 20, 1, GREEN);
        probe("fs_nocommit_new", 300, 300, 1, BG);

        // Write coinciding with commit+frame_start stays in shadow only.
        wr_en = 1; wr_idx = 0; wr_x = 400; wr_y = 400; wr_color = YEL; wr_vis = 1;
        commit = 1; frame_start = 1;
        idle();
        check("same_cycle_pending", 32'(commit_pending), 32'd0);
        probe("same_cycle_committed", 300, 300, 1, WHITE);
        probe("same_cycle_excluded", 400, 400, 1, BG);
        commit_and_swap();
        probe("later_commit_new", 400, 400, 1, YEL);
        probe("later_commit_old", 300, 300, 1, BG);

        // Reset in the middle of a line with bodies live.
        for (int x = 395; x < 402; x++) pix(x, 400, 1);
        rst = 1;
        pix(402, 400, 1);
        check("midreset_rgb", {8'h0, r, g, b}, 32'h0);
        check("midreset_hsync", 32'(hsync_out), 32'd1);
        check("midreset_vsync", 32'(vsync_out), 32'd1);
        check("midreset_blank_n", 32'(blank_n_out), 32'd0);
        rst = 0;
        scan(396, 406, 398, 405, BG, cnt);
        check("post_reset_bg", 32'(cnt), 32'd88);
        commit_and_swap();
        scan(18, 27, 18, 27, BG, cnt);
        check("post_reset_shadow_clear", 32'(cnt), 32'd100);

        // Randomized traffic in a small window plus the bottom-right corner.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                wr_en = 1; wr_idx = 2'($urandom); wr_vis = 1'($urandom_range(0, 3) != 0);
                wr_color = 24'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    wr_x = 10'($urandom_range(630, 1023)); wr_y = 9'($urandom_range(470, 511));
                end else begin
                    wr_x = 10'($urandom_range(0, 43)); wr_y = 9'($urandom_range(0, 43));
                end
            end
            if ($urandom_range(0, 19) == 0) commit = 1;
            if ($urandom_range(0, 39) == 0) frame_start = 1;
            if ($urandom_range(0, 7) == 0) pix(int'($urandom_range(628, 639)),
                                               int'($urandom_range(468, 479)), !frame_start);
            else pix(int'($urandom_range(0, 47)), int'($urandom_range(0, 47)),
                     !frame_start && ($urandom_range(0, 9) != 0));
        end
        idle(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
